image_stream_scorer: RTL and testbench

IMAGE_STREAM_SCORER -- requirements
Module: image_stream_scorer

---
 rtl/image_stream_scorer.sv | 186 ++++++++++++++++++
 tb/tb_image_stream_scorer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_scorer.sv
// Streams stored images into an accelerator and scores its decisions per class.
// Define RAND_SEL_EN to pick images with a 16-bit LFSR instead of sequentially.
module image_stream_scorer #(
    parameter int PIX_W     = 8,
    parameter int NPIX      = 784,
    parameter int NUM_IMG   = 1000,
    parameter int NUM_CLASS = 10,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 4095,
    localparam int AW = $clog2(NUM_IMG * NPIX),
    localparam int IW = $clog2(NUM_IMG),
    localparam int LW = $clog2(NUM_CLASS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_run,
    output logic [AW-1:0]    mem_addr,
    input  logic [PIX_W-1:0] mem_data,
    output logic [IW-1:0]    lbl_addr,
    input  logic [LW-1:0]    lbl_data,
    output logic             acc_rst_n,
    output logic [PIX_W-1:0] data_in,
    input  logic [LW-1:0]    decision,
    input  logic             finish,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_total,
    output logic [CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    input  logic [LW-1:0]    rd_class,
    output logic [CNT_W-1:0] rd_hit,
    output logic [CNT_W-1:0] rd_miss
);

    localparam int PW = $clog2(NPIX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [LW:0] NCL = (LW + 1)'(NUM_CLASS);

    typedef enum logic [2:0] {
        IDLE, SELECT, ARST, STREAM, WAIT, SCORE, FIN
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] run_len;
    logic [IW-1:0]    cur_img, img_sel;
    logic [LW-1:0]    label, dec_q;
    logic             timed_out;
    logic [PW-1:0]    pix;
    logic [TW-1:0]    wcnt;
    logic [CNT_W-1:0] hit_cnt  [NUM_CLASS];
    logic [CNT_W-1:0] miss_cnt [NUM_CLASS];
    logic             last_img, wait_exp, lbl_ok, is_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

`ifdef RAND_SEL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= 16'hACE1;
        else if (state == SELECT)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign img_sel = IW'({16'd0, lfsr} % NUM_IMG);
`else
    logic [IW-1:0] seq_img;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seq_img <= '0;
        else if (state == IDLE && start)
            seq_img <= '0;
        else if (state == SELECT)
            seq_img <= (seq_img == IW'(NUM_IMG - 1)) ? '0 : seq_img + 1'b1;
    end

    assign img_sel = seq_img;
`endif

    // run_cnt+1 is formed one bit wider so a full-scale num_run still ends
    assign last_img = ({1'b0, run_cnt} + 1'b1) >= {1'b0, run_len};
    assign wait_exp = (wcnt == TW'(TIMEOUT - 1));
    assign lbl_ok   = ({1'b0, label} < NCL);
    assign is_hit   = !timed_out && (dec_q == label) && ({1'b0, dec_q} < NCL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = (num_run != '0) ? SELECT : FIN;
            SELECT:  state_nx = ARST;
            ARST:    state_nx = STREAM;
            STREAM:  if (pix == PW'(NPIX)) state_nx = WAIT;
            WAIT:    if (finish || wait_exp) state_nx = SCORE;
            SCORE:   state_nx = last_img ? FIN : SELECT;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len     <= '0;
            cur_img     <= '0;
            label       <= '0;
            dec_q       <= '0;
            timed_out   <= 1'b0;
            pix         <= '0;
            wcnt        <= '0;
            mem_addr    <= '0;
            hit_total   <= '0;
            run_cnt     <= '0;
            timeout_cnt <= '0;
            for (int c = 0; c < NUM_CLASS; c++) begin
                hit_cnt[c]  <= '0;
                miss_cnt[c] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: if (start && num_run != '0) begin
                    run_len     <= num_run;
                    hit_total   <= '0;
                    run_cnt     <= '0;
                    timeout_cnt <= '0;
                    for (int c = 0; c < NUM_CLASS; c++) begin
                        hit_cnt[c]  <= '0;
                        miss_cnt[c] <= '0;
                    end
                end
                SELECT: cur_img <= img_sel;
                ARST: begin
                    label    <= lbl_data;
                    pix      <= '0;
                    mem_addr <= AW'(cur_img) * AW'(NPIX);
                end
                STREAM: begin
                    pix  <= pix + 1'b1;
                    wcnt <= '0;
                    if (pix < PW'(NPIX - 1))
                        mem_addr <= mem_addr + 1'b1;
                    else
                        mem_addr <= '0;
                end
                // the last WAIT cycle decides: finish wins over expiry
                WAIT: begin
                    wcnt      <= wcnt + 1'b1;
                    dec_q     <= decision;
                    timed_out <= !finish;
                end
                SCORE: begin
                    if (is_hit) begin
                        hit_total <= sat_inc(hit_total);
                        if (lbl_ok) hit_cnt[label] <= sat_inc(hit_cnt[label]);
                    end else if (lbl_ok) begin
                        miss_cnt[label] <= sat_inc(miss_cnt[label]);
                    end
                    if (timed_out) timeout_cnt <= sat_inc(timeout_cnt);
                    run_cnt <= sat_inc(run_cnt);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign acc_rst_n = rst_n && (state != ARST);
    assign data_in   = (state == STREAM && pix != '0) ? mem_data : '0;
    assign lbl_addr  = (state == SELECT) ? img_sel : cur_img;
    assign rd_hit    = ({1'b0, rd_class} < NCL) ? hit_cnt[rd_class] : '0;
    assign rd_miss   = ({1'b0, rd_class} < NCL) ? miss_cnt[rd_class] : '0;

endmodule

// File: tb/tb_image_stream_scorer.sv
// Directed/randomized bench for image_stream_scorer (sequential selection).
// Memory and accelerator models live here; expected scores come from plain counting.
module tb_image_stream_scorer;

    localparam int PIX_W     = 8;
    localparam int NPIX      = 16;
    localparam int NUM_IMG   = 4;
    localparam int NUM_CLASS = 10;
    localparam int CNT_W     = 5;
    localparam int TIMEOUT   = 15;
    localparam int AW   = $clog2(NUM_IMG * NPIX);
    localparam int IW   = $clog2(NUM_IMG);
    localparam int LW   = $clog2(NUM_CLASS);
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, start, finish;
    logic [CNT_W-1:0] num_run;
    logic [AW-1:0]    mem_addr;
    logic [PIX_W-1:0] mem_data;
    logic [IW-1:0]    lbl_addr;
    logic [LW-1:0]    lbl_data, decision, rd_class;
    logic             acc_rst_n, busy, done;
    logic [PIX_W-1:0] data_in;
    logic [CNT_W-1:0] hit_total, run_cnt, timeout_cnt, rd_hit, rd_miss;

    logic [PIX_W-1:0] store  [NUM_IMG*NPIX];
    logic [LW-1:0]    labels [NUM_IMG];

    int errors = 0;
    int checks = 0;

    image_stream_scorer #(
        .PIX_W(PIX_W), .NPIX(NPIX), .NUM_IMG(NUM_IMG),
        .NUM_CLASS(NUM_CLASS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_run(num_run),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .lbl_addr(lbl_addr), .lbl_data(lbl_data),
        .acc_rst_n(acc_rst_n), .data_in(data_in),
        .decision(decision), .finish(finish),
        .busy(busy), .done(done),
        .hit_total(hit_total), .run_cnt(run_cnt), .timeout_cnt(timeout_cnt),
        .rd_class(rd_class), .rd_hit(rd_hit), .rd_miss(rd_miss)
    );

    always #5 clk = ~clk;

    // synchronous stores with one cycle of read latency
    always @(posedge clk) begin
        mem_data <= store[mem_addr];
        lbl_data <= labels[lbl_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // which=0: wait for accelerator reset, which=1: wait for done
    task automatic wait_for(input int which, input int limit,
                            output int cnt, output bit ok, output bit early);
        ok = 1'b0; early = 1'b0; cnt = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            cnt = k;
            if (which == 0 && done === 1'b1) early = 1'b1;
            if (which == 0 ? (acc_rst_n === 1'b0) : (done === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // mode: 0 correct, 1 wrong class, 2 no finish, 3 out-of-range, 4 random mix
    task automatic do_run(input int n, input int mode, input int abort_at);
        int e_hit [NUM_CLASS];
        int e_miss[NUM_CLASS];
        int e_to, e_tot, cnt, img, lab, m, prev_m, sum_got, sum_exp, exp_gap;
        bit ok, early, seen;
        for (int c = 0; c < NUM_CLASS; c++) begin e_hit[c] = 0; e_miss[c] = 0; end
        e_to = 0; e_tot = 0; prev_m = 0;
        @(negedge clk);
        start = 1'b1; num_run = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 1);
            @(negedge clk);
            chk("zero_done_end", done, 0);
            chk("zero_idle", busy, 0);
            chk("zero_hit_total", hit_total, 0);
            chk("zero_run_cnt", run_cnt, 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            img = i % NUM_IMG;
            lab = int'(labels[img]);
            m = (mode == 4) ? int'($urandom_range(0, 3)) : mode;
            wait_for(0, TIMEOUT + 8, cnt, ok, early);
            chk("arst_seen", ok, 1);
            if (!ok) begin
                rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
                return;
            end
            chk("early_done", early, 0);
            exp_gap = (i == 0) ? 1 : ((prev_m == 2) ? TIMEOUT + 3 : 2);
            chk("arst_gap", cnt, exp_gap);
            if (i == 0) chk("busy_run", busy, 1);
            sum_got = 0; sum_exp = 0;
            for (int k = 0; k <= NPIX; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    chk("mem_addr0", mem_addr, img * NPIX);
                    chk("data_in_lead", data_in, 0);
                end else begin
                    sum_got += k * int'(data_in);
                    sum_exp += k * int'(store[img*NPIX + k - 1]);
                    if (k == 1) chk("first_pix", data_in, store[img*NPIX]);
                end
                if (k == 2) begin finish = 1'b1; decision = LW'((lab + 1) % NUM_CLASS); end
                if (k == 3) finish = 1'b0;
                if (i == 0 && k == 3) begin start = 1'b1; num_run = CNT_W'(1); end
                if (i == 0 && k == 4) start = 1'b0;
                if (i == abort_at && k == 5) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_acc_rst_n", acc_rst_n, 0);
                    chk("rst_data_in", data_in, 0);
                    chk("rst_mem_addr", mem_addr, 0);
                    chk("rst_lbl_addr", lbl_addr, 0);
                    chk("rst_hit_total", hit_total, 0);
                    chk("rst_run_cnt", run_cnt, 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    seen = 1'b0;
                    repeat (20) begin
                        @(negedge clk);
                        if (done === 1'b1) seen = 1'b1;
                    end
                    chk("rst_no_done", seen, 0);
                    chk("rst_idle", busy, 0);
                    return;
                end
            end
            chk("pix_sum", sum_got, sum_exp);
            if (m != 2) begin
                for (int w = 1; w <= 10; w++) begin
                    @(negedge clk);
                    if (w == 1) chk("data_in_wait", data_in, 0);
                end
                finish = 1'b1;
                if (m == 0)      decision = LW'(lab);
                else if (m == 1) decision = LW'((lab + 1) % NUM_CLASS);
                else decision = LW'(NUM_CLASS + int'($urandom_range(0, (1 << LW) - 1 - NUM_CLASS)));
                @(negedge clk);
                finish = 1'b0;
                decision = LW'($urandom);
            end
            if (m == 0) begin e_hit[lab]++; e_tot++; end
            else e_miss[lab]++;
            if (m == 2) e_to++;
            prev_m = m;
        end
        wait_for(1, TIMEOUT + 8, cnt, ok, early);
        chk("done_seen", ok, 1);
        chk("done_lat", cnt, (prev_m == 2) ? TIMEOUT + 2 : 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_after", busy, 0);
        chk("hit_total", hit_total, sat(e_tot));
        chk("run_cnt", run_cnt, sat(n));
        chk("timeout_cnt", timeout_cnt, sat(e_to));
        for (int c = 0; c < NUM_CLASS; c++) begin
            rd_class = LW'(c);
            #1;
            chk("rd_hit", rd_hit, sat(e_hit[c]));
            chk("rd_miss", rd_miss, sat(e_miss[c]));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_run = '0;
        finish = 1'b0; decision = '0; rd_class = '0;
        for (int i = 0; i < NUM_IMG*NPIX; i++) store[i] = PIX_W'($urandom);
        for (int i = 0; i < NUM_IMG; i++) labels[i] = LW'($urandom_range(0, NUM_CLASS - 1));
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_acc_rst_n", acc_rst_n, 0);
        chk("reset_data_in", data_in, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_lbl_addr", lbl_addr, 0);
        chk("reset_hit_total", hit_total, 0);
        chk("reset_run_cnt", run_cnt, 0);
        chk("reset_timeout_cnt", timeout_cnt, 0);
        chk("reset_rd_hit", rd_hit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_acc", acc_rst_n, 1);

        do_run(3, 0, -1);
        do_run(20, 1, -1);
        do_run(2, 2, -1);
        do_run(6, 0, -1);
        do_run(4, 3, -1);
        do_run(12, 4, -1);
        do_run(31, 0, -1);
        do_run(6, 0, 2);
        do_run(0, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
